// File: rtl/mem_stage_datamem.sv
// MEM-stage data memory: byte/half/word loads and stores with a wait-state stall FSM.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_datamem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_ALU_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic [31:0] out_rdata,
  output logic        out_valid,
  output logic        out_stall,
  output logic        out_misalign
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Stall cycles still owed after the request cycle itself.
  localparam logic [3:0] WsLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req, stall, commit, access, is_wr, is_rd, mis, wr_en;
  logic [AW-1:0] idx;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rword, load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  assign req         = in_MemRead | in_MemWrite;
  assign idx         = in_ALU_addr[AW+1:2];
  assign off         = in_ALU_addr[1:0];
  assign unused_addr = ^in_ALU_addr[31:AW+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            commit = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = WsLoad;
            state_d = (WAIT_STATES == 1) ? StCommit : StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (!req) begin
          // Request flushed upstream: abandon the access without writing.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StCommit;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign access = commit & req & rst_n;
  assign is_wr  = access & in_MemWrite;
  assign is_rd  = access & in_MemRead & ~in_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = ((in_size == 2'b01) & off[0]) | (in_size[1] & (off != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign wr_en        = is_wr & ~mis;
  assign out_stall    = stall & rst_n;
  assign out_misalign = access & mis;
  assign out_valid    = is_rd & ~mis;
  assign out_rdata    = out_valid ? load_data : 32'd0;

  always_comb begin
    rword     = mem[idx];
    be        = 4'b1111;
    wdata_rep = in_wdata;
    load_data = rword;
    byte_v    = rword[{off, 3'b000} +: 8];
    half_v    = off[1] ? rword[31:16] : rword[15:0];
    if (in_size == 2'b00) begin
      be        = 4'b0001 << off;
      wdata_rep = {4{in_wdata[7:0]}};
      load_data = {{24{~in_unsigned & byte_v[7]}}, byte_v};
    end else if (in_size == 2'b01) begin
      be        = off[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{in_wdata[15:0]}};
      load_data = {{16{~in_unsigned & half_v[15]}}, half_v};
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule
